// File: rtl/demux8_sched.sv
// Round-robin scheduler in front of a 1-to-8 serial demux: grants one requester a window
// of up to HOLD accepted beats and routes the input bit to it. Define DEMUX8_SCHED_ROUND_ROBIN_EN for rotating priority.
module demux8_sched #(
   parameter int unsigned HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic [7:0] d,
   output logic       dv,
   output logic       busy
);

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   localparam logic [7:0] LAST_BEAT = 8'(HOLD - 1);

   state_t     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] gnt_q, gnt_d;
   logic [7:0] d_q, d_d;
   logic       dv_q, dv_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] win;

`ifdef DEMUX8_SCHED_ROUND_ROBIN_EN
   logic [2:0] ptr_q, ptr_d;
   logic       found;

   // First set request bit scanning upward from ptr, wrapping 7 -> 0.
   always_comb begin
      win   = ptr_q;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!found && req[ptr_q + 3'(i)]) begin
            win   = ptr_q + 3'(i);
            found = 1'b1;
         end
      end
   end
`else
   // Fixed priority: lowest set bit wins.
   always_comb begin
      win = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (req[i]) begin
            win = 3'(i);
         end
      end
   end
`endif

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_d = state_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      d_d     = '0;
      dv_d    = 1'b0;
`ifdef DEMUX8_SCHED_ROUND_ROBIN_EN
      ptr_d   = ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req != 8'd0) begin
               state_d = XFER;
               sel_d   = win;
               gnt_d   = 8'd1 << win;
               cnt_d   = '0;
            end
         end
         XFER: begin
            dv_d       = in_valid;
            d_d[sel_q] = in & in_valid;
            if (in_valid) begin
               cnt_d = cnt_q + 8'd1;
            end
            // A beat arriving with the request drop is still delivered above.
            if ((in_valid && (cnt_q == LAST_BEAT)) || !req[sel_q]) begin
               state_d = IDLE;
               gnt_d   = '0;
`ifdef DEMUX8_SCHED_ROUND_ROBIN_EN
               ptr_d   = sel_q + 3'd1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         gnt_q   <= '0;
         d_q     <= '0;
         dv_q    <= 1'b0;
         cnt_q   <= '0;
`ifdef DEMUX8_SCHED_ROUND_ROBIN_EN
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         d_q     <= d_d;
         dv_q    <= dv_d;
         cnt_q   <= cnt_d;
`ifdef DEMUX8_SCHED_ROUND_ROBIN_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign in_ready = (state_q == XFER);
   assign busy     = (state_q == XFER);
   assign gnt      = gnt_q;
   assign sel      = sel_q;
   assign d        = d_q;
   assign dv       = dv_q;

endmodule

// File: tb/tb_demux8_sched.sv
// Scoreboard bench for demux8_sched: a cycle-level window model predicts grants and the
// delivered beat stream; a separate monitor pops expected beats whenever dv is high.
module tb_demux8_sched;

   localparam int HOLD = 4;

   typedef struct {
      int ch;
      bit b;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       din;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic [7:0] d;
   logic       dv;
   logic       busy;

   int    n_vec  = 0;
   int    n_fail = 0;
   beat_t exp_q[$];

   // Reference model: whether a window is open, its channel, beats taken, rotation start.
   bit m_open;
   int m_ch;
   int m_cnt;
`ifdef DEMUX8_SCHED_ROUND_ROBIN_EN
   int m_ptr;
`endif

   demux8_sched #(.HOLD(HOLD)) dut (
      .clk      (clk),
      .rst      (rst),
      .in       (din),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .req      (req),
      .gnt      (gnt),
      .sel      (sel),
      .d        (d),
      .dv       (dv),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_open = 1'b0;
      m_ch   = 0;
      m_cnt  = 0;
`ifdef DEMUX8_SCHED_ROUND_ROBIN_EN
      m_ptr  = 0;
`endif
      exp_q.delete();
   endtask

   function automatic int pick(input logic [7:0] r);
      int base;
`ifdef DEMUX8_SCHED_ROUND_ROBIN_EN
      base = m_ptr;
`else
      base = 0;
`endif
      for (int i = 0; i < 8; i++) begin
         if (r[(base + i) % 8]) return (base + i) % 8;
      end
      return 0;
   endfunction

   task automatic model_step(input logic [7:0] r, input bit v, input bit b);
      if (!m_open) begin
         if (r != 8'd0) begin
            m_open = 1'b1;
            m_ch   = pick(r);
            m_cnt  = 0;
         end
      end else begin
         if (v) begin
            exp_q.push_back('{m_ch, b});
            m_cnt++;
         end
         if ((v && m_cnt == HOLD) || !r[m_ch]) begin
            m_open = 1'b0;
`ifdef DEMUX8_SCHED_ROUND_ROBIN_EN
            m_ptr  = (m_ch + 1) % 8;
`endif
         end
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".gnt"}, 32'(gnt), m_open ? (32'd1 << m_ch) : 32'd0);
      check({tag, ".sel"}, 32'(sel), 32'(m_ch));
      check({tag, ".in_ready"}, 32'(in_ready), 32'(m_open));
      check({tag, ".busy"}, 32'(busy), 32'(m_open));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".gnt"}, 32'(gnt), 32'd0);
      check({tag, ".sel"}, 32'(sel), 32'd0);
      check({tag, ".d"}, 32'(d), 32'd0);
      check({tag, ".dv"}, 32'(dv), 32'd0);
      check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd0);
   endtask

   task automatic cycle(input string tag, input logic [7:0] r, input bit v, input bit b);
      @(negedge clk);
      check_state(tag);
      req      = r;
      in_valid = v;
      din      = b;
      model_step(r, v, b);
   endtask

   // Monitor: every delivered beat must match the head of the expected stream.
   initial begin : monitor
      beat_t e;
      forever begin
         @(posedge clk);
         #1;
         if (dv) begin
            if (exp_q.size() == 0) begin
               check("beat.unexpected_dv", 32'(dv), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("beat.d", 32'(d), e.b ? (32'd1 << e.ch) : 32'd0);
               check("beat.sel", 32'(sel), 32'(e.ch));
            end
         end else begin
            check("nobeat.d", 32'(d), 32'd0);
         end
      end
   end

   initial begin
      logic [7:0] r;
      rst      = 1'b1;
      req      = '0;
      in_valid = 1'b0;
      din      = 1'b0;
      model_reset();

      // Reset held with random inputs.
      repeat (4) begin
         @(negedge clk);
         req      = 8'($urandom);
         in_valid = 1'($urandom);
         din      = 1'($urandom);
         #1 check_all_zero("reset");
      end
      @(negedge clk);
      req      = '0;
      in_valid = 1'b0;
      din      = 1'b0;
      rst      = 1'b0;
      repeat (3) cycle("post_reset_idle", 8'h00, 1'b0, 1'b0);

      // Single requester, data 1,0,1,1.
      cycle("single", 8'h20, 1'b0, 1'b0);
      cycle("single", 8'h20, 1'b1, 1'b1);
      cycle("single", 8'h20, 1'b1, 1'b0);
      cycle("single", 8'h20, 1'b1, 1'b1);
      cycle("single", 8'h20, 1'b1, 1'b1);
      cycle("single", 8'h00, 1'b0, 1'b0);
      cycle("single", 8'h00, 1'b0, 1'b0);

      // All requesters: fairness order (or channel 0 every time without rotation).
      repeat (46) cycle("all_req", 8'hFF, 1'b1, 1'($urandom));
      repeat (2) cycle("all_req_end", 8'h00, 1'b0, 1'b0);

      // Early release on the second beat of channel 3.
      cycle("early", 8'h08, 1'b0, 1'b0);
      cycle("early", 8'h08, 1'b1, 1'b1);
      cycle("early", 8'h00, 1'b1, 1'b1);
      cycle("early", 8'h00, 1'b0, 1'b0);
      cycle("early", 8'h00, 1'b0, 1'b0);

      // Wrap-around: close a channel-6 window so rotation starts at 7.
      cycle("wrap", 8'h40, 1'b0, 1'b0);
      cycle("wrap", 8'h00, 1'b0, 1'b0);
      repeat (12) cycle("wrap", 8'h81, 1'b1, 1'($urandom));
      repeat (2) cycle("wrap_end", 8'h00, 1'b0, 1'b0);

      // Reset mid-window with two beats accepted and a third in flight.
      cycle("midrst", 8'h10, 1'b0, 1'b0);
      cycle("midrst", 8'h10, 1'b1, 1'b1);
      cycle("midrst", 8'h10, 1'b1, 1'b1);
      @(negedge clk);
      check_state("midrst");
      req      = 8'h10;
      in_valid = 1'b1;
      din      = 1'b1;
      #2 rst   = 1'b1;
      model_reset();
      #1 check_all_zero("midrst_async");
      @(negedge clk);
      check_all_zero("midrst_held");
      rst      = 1'b0;
      req      = 8'h00;
      in_valid = 1'b0;
      din      = 1'b0;
      model_step(8'h00, 1'b0, 1'b0);
      repeat (8) cycle("restart", 8'hFF, 1'b1, 1'($urandom));
      repeat (2) cycle("restart_end", 8'h00, 1'b0, 1'b0);

      // Randomized traffic with requests that persist for a few cycles.
      r = 8'($urandom);
      repeat (400) begin
         if ($urandom_range(3) == 0) r = 8'($urandom);
         cycle("random", r, 1'($urandom), 1'($urandom));
      end

      repeat (4) cycle("drain", 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      check("scoreboard.left_over", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/demux8_sched.md
# demux8_sched

Round-robin scheduler that shares the 1-to-8 demultiplexer datapath among eight destination requesters. It arbitrates between the requesters, holds the select lines for one grant window of up to `HOLD` accepted beats, and routes the serial input bit stream to the granted destination. Outputs are registered. The block sits between the serial source and the eight destination channels.

## Interface
- `HOLD`, default 4: maximum accepted beats per grant window; legal range 1..255.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in` input 1: serial data bit from the source.
- `in_valid` input 1: `in` carries a beat this cycle.
- `in_ready` output 1: the block accepts a beat this cycle; a beat transfers when `in_valid & in_ready`.
- `req` input 8: per-destination request; `req[i]=1` means channel i wants data.
- `gnt` output 8: one-hot grant, or all zero.
- `sel` output 3: demux select (s2..s0 = `sel[2:0]`); index of the current or last grant.
- `d` output 8: demux data outputs; only `d[sel]` can be 1.
- `dv` output 1: `d` holds a beat delivered this cycle.
- `busy` output 1: a grant window is open.

## Operation
- FSM has two states, `IDLE` and `XFER`. Internal state:
  - `ptr[2:0]`: round-robin pointer.
  - `cnt[7:0]`: count of accepted beats in the current window.
- `IDLE`:
  - `in_ready=0`.
  - If `req==0`, stay in `IDLE`.
  - Otherwise pick the winner w. With round-robin priority, w is the first set bit of `req` scanning `ptr, ptr+1, … ptr+7` (mod 8).
  - Next state is `XFER`. Load `sel<=w`, `gnt<=1<<w`, `cnt<=0`.
- `XFER`:
  - `in_ready=1` and `busy=1`.
  - On each edge: `dv<=in_valid`. `d<=0`, except `d[sel]<=in & in_valid`. If `in_valid`, `cnt<=cnt+1`.
- Window ends at the edge where either condition holds:
  - an accepted beat brings the count to `HOLD` (`in_valid` and `cnt==HOLD-1`), or
  - `req[sel]==0`.
- When the window ends:
  - Next state is `IDLE` and `gnt<=0`; `sel` keeps its value.
  - Round-robin mode: `ptr<=sel+1`, wrapping 7→0.
- Simultaneous beat and `req[sel]` drop: the beat is delivered (`d` and `dv` update), then the window closes.
- In `IDLE`, `dv<=0` and `d<=0` on every edge.
- `req` changes on channels other than `sel` during `XFER` are ignored until the next `IDLE`.

## Timing
- Reset values: state `IDLE`, `ptr=0`, `sel=0`, `gnt=0`, `d=0`, `dv=0`, `cnt=0`, `in_ready=0`, `busy=0`.
- `in_ready` and `busy` decode directly from the state register. No combinational path exists from `in_valid` or `req` to any output.
- Grant latency: `req` sampled in `IDLE` at edge N gives `gnt`, `sel`, `in_ready` and `busy` valid in cycle N+1.
- Data latency: a beat accepted in cycle k appears on `d`/`dv` in cycle k+1.
- At least one `IDLE` cycle separates consecutive windows, so `in_ready` drops for at least one cycle between grants.
- Maximum window length is unbounded while `in_valid=0` and `req[sel]=1`. `HOLD` counts accepted beats, not cycles.
- Reset asserted mid-window clears everything immediately. A beat accepted in the same cycle is lost and no `dv` pulse follows.

## Configuration
- `DEMUX8_SCHED_ROUND_ROBIN_EN` defined: rotating priority with `ptr`, as described above.
- Undefined: fixed priority, channel 0 highest. `ptr` is not implemented and the winner is the lowest set bit of `req`.

## Test plan
- Reset: hold `rst=1` with random inputs → all outputs 0. Release with `req=0` → stays idle, `in_ready=0`.
- Single requester, `HOLD=4`: `req=8'h20`, `in_valid=1`, data 1,0,1,1 →
  - cycle 1: `gnt=8'h20`, `sel=5`;
  - `d[5]` follows 1,0,1,1 one cycle later, with `dv=1` for 4 cycles;
  - then `gnt=0` and `in_ready=0` for at least one cycle.
- Round-robin fairness: `req=8'hFF` held, `in_valid=1` → grant order 0,1,2,…,7,0, each window exactly 4 beats. Undefined-macro build → always channel 0.
- Early release: grant channel 3, drop `req[3]` on the same cycle as the 2nd beat → 2nd beat delivered on `d[3]`, window closes, next `ptr=4`.
- Wrap-around: `ptr=7` with `req=8'h81` → grants channel 7 first, then channel 0.
- Reset mid-window: assert `rst` while `cnt=2` → outputs 0 immediately, no `dv` for the in-flight beat. Restart grants from channel 0.
